mac_tx_arbiter: RTL and testbench

- Shares the single mac_encode TX path between N frame sources, for example the ARP responder (port 0) and a future IP/ICMP encoder (port 1).
- Grants one source per frame using round-robin arbitration.
- Latches that source's destination MAC and ethertype, then drives mac_encode's en/mac_dest/ethertype/mac_payload.
- Returns mac_encode's send_next strobe to the granted source only, and enforces a minimum idle gap between frames.

---
 rtl/mac_tx_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
//
// Purpose:
//   Shares one mac_encode TX path between N frame sources. A single source is
//   granted per frame using round-robin arbitration. At grant time the source's
//   destination MAC and ethertype are latched and held for the whole frame.
//   The payload is then streamed through a one-cycle register toward the
//   encoder. The encoder's send_next strobe is returned to the granted source
//   only. An idle gap of IFG_CYCLES clocks is forced between frames, and a
//   frame that reaches MAX_BYTES payload bytes is cut with a one-cycle abort
//   pulse.
//
// Handshake:
//   A source raises src_req[i] and holds it until src_grant[i] rises. While it
//   is granted, a byte presented on src_dout slice i with src_ovalid[i]=1 is
//   consumed on every clock edge where src_next[i] is high. src_next[i] is
//   enc_send_next gated by the grant, and the byte appears on enc_payload one
//   clock later. Dropping src_ovalid[i] while granted ends the frame on the
//   next edge.
//
// Ports:
//   clk            TX clock (mac_encode domain)
//   rst            asynchronous, active-low reset
//   src_req        [N]     frame pending per source
//   src_dest       [48*N]  destination MAC per source, sampled at grant
//   src_ethertype  [16*N]  ethertype per source, sampled at grant
//   src_dout       [8*N]   payload byte per source
//   src_ovalid     [N]     payload byte valid per source (low = end of payload)
//   src_next       [N]     byte-accept strobe back to the granted source
//   src_grant      [N]     one-hot grant, high for the whole frame
//   enc_en         mac_encode en (equal to |src_grant)
//   enc_dest       mac_encode mac_dest
//   enc_ethertype  mac_encode ethertype
//   enc_payload    mac_encode mac_payload
//   enc_send_next  mac_encode send_next
//   abort          one-cycle pulse when a frame is cut at MAX_BYTES
//   dbg_state      current FSM state (0 idle, 1 stream, 2 abort, 3 gap)
// -----------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int N          = 2,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_BYTES  = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      src_req,
    input  logic [48*N-1:0]   src_dest,
    input  logic [16*N-1:0]   src_ethertype,
    input  logic [8*N-1:0]    src_dout,
    input  logic [N-1:0]      src_ovalid,
    output logic [N-1:0]      src_next,
    output logic [N-1:0]      src_grant,
    output logic              enc_en,
    output logic [47:0]       enc_dest,
    output logic [15:0]       enc_ethertype,
    output logic [7:0]        enc_payload,
    input  logic              enc_send_next,
    output logic              abort,
    output logic [1:0]        dbg_state
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Last accepted byte index before a frame is cut.
    localparam logic [15:0] CNT_LAST = 16'(MAX_BYTES - 1);
    // Gap counter value on which GAP hands back to IDLE. A gap of 0 or 1
    // cycles both collapse to a single GAP cycle.
    localparam logic [15:0] GAP_LAST = (IFG_CYCLES <= 1) ? 16'd0 : 16'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_ABORT  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [47:0]     dest_q, dest_d;
    logic [15:0]     ety_q, ety_d;
    logic [7:0]      payload_q, payload_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]     gap_cnt_q, gap_cnt_d;
    logic            abort_q, abort_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: the first requester at or after rr_ptr, wrapping.
    // -------------------------------------------------------------------------
    logic            req_any;
    logic [PW-1:0]   req_sel;
    logic [PW-1:0]   cand;

    always_comb begin
        req_any = 1'b0;
        req_sel = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % N);
            if (!req_any && src_req[cand]) begin
                req_any = 1'b1;
                req_sel = cand;
            end
        end
    end

    // Signals of the currently granted source.
    logic            cur_ovalid;
    logic [7:0]      cur_dout;
    logic [PW-1:0]   next_ptr;

    always_comb begin
        cur_ovalid = src_ovalid[gidx_q];
        cur_dout   = src_dout[8*int'(gidx_q) +: 8];
        // The source just served moves to the lowest priority.
        next_ptr   = PW'((int'(gidx_q) + 1) % N);
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        dest_d     = dest_q;
        ety_d      = ety_q;
        payload_d  = payload_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        abort_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    grant_d    = N'(1) << req_sel;
                    gidx_d     = req_sel;
                    dest_d     = src_dest[48*int'(req_sel) +: 48];
                    ety_d      = src_ethertype[16*int'(req_sel) +: 16];
                    byte_cnt_d = '0;
                    state_d    = S_STREAM;
                end
            end

            S_STREAM: begin
                if (!cur_ovalid) begin
                    // End of payload: close the frame and start the gap.
                    grant_d   = '0;
                    payload_d = '0;
                    rr_ptr_d  = next_ptr;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (enc_send_next) begin
                    payload_d  = cur_dout;
                    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    // Limit byte accepted: take it, then cut the frame next cycle.
                    if (byte_cnt_q == CNT_LAST) begin
                        state_d = S_ABORT;
                    end
                end
            end

            S_ABORT: begin
                // src_next is already blocked here, so no extra byte is taken.
                grant_d   = '0;
                payload_d = '0;
                rr_ptr_d  = next_ptr;
                gap_cnt_d = '0;
                abort_d   = 1'b1;
                state_d   = S_GAP;
            end

            S_GAP: begin
                gap_cnt_d = (gap_cnt_q == 16'hFFFF) ? gap_cnt_q : gap_cnt_q + 16'd1;
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            dest_q     <= '0;
            ety_q      <= '0;
            payload_q  <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            dest_q     <= dest_d;
            ety_q      <= ety_d;
            payload_q  <= payload_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The grant is one-hot, so gating it with send_next routes the strobe to
    // the granted source only. Outside STREAM the strobe is dropped.
    assign src_next      = (state_q == S_STREAM && enc_send_next) ? grant_q : '0;
    assign src_grant     = grant_q;
    assign enc_en        = |grant_q;
    assign enc_dest      = dest_q;
    assign enc_ethertype = ety_q;
    assign enc_payload   = payload_q;
    assign abort         = abort_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;

    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  src_req = '0;
    logic [95:0] src_dest = '0;
    logic [31:0] src_ethertype = '0;
    logic [15:0] src_dout = '0;
    logic [1:0]  src_ovalid = '0;
    logic        enc_send_next = 1'b0;

    logic [1:0]  src_next, src_grant;
    logic        enc_en, abort;
    logic [47:0] enc_dest;
    logic [15:0] enc_ethertype;
    logic [7:0]  enc_payload;
    logic [1:0]  dbg_state;

    logic [1:0]  m_src_next, m_src_grant;
    logic        m_enc_en, m_abort;
    logic [47:0] m_enc_dest;
    logic [15:0] m_enc_ethertype;
    logic [7:0]  m_enc_payload;
    logic [1:0]  m_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_tx_arbiter #(.N(2), .IFG_CYCLES(IFG), .MAX_BYTES(1500)) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_dest(src_dest),
        .src_ethertype(src_ethertype), .src_dout(src_dout), .src_ovalid(src_ovalid),
        .src_next(src_next), .src_grant(src_grant), .enc_en(enc_en),
        .enc_dest(enc_dest), .enc_ethertype(enc_ethertype), .enc_payload(enc_payload),
        .enc_send_next(enc_send_next), .abort(abort), .dbg_state(dbg_state)
    );

    mac_tx_arbiter #(.N(2), .IFG_CYCLES(IFG), .MAX_BYTES(4)) dut_m (
        .clk(clk), .rst(rst), .src_req(src_req), .src_dest(src_dest),
        .src_ethertype(src_ethertype), .src_dout(src_dout), .src_ovalid(src_ovalid),
        .src_next(m_src_next), .src_grant(m_src_grant), .enc_en(m_enc_en),
        .enc_dest(m_enc_dest), .enc_ethertype(m_enc_ethertype), .enc_payload(m_enc_payload),
        .enc_send_next(enc_send_next), .abort(m_abort), .dbg_state(m_dbg_state)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_req = '0;
        src_ovalid = '0;
        src_dout = '0;
        enc_send_next = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enc_send_next = 1'b1;
        src_req = 2'b11;
        #1;
        n_tests++; if (enc_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", enc_en); end
        n_tests++; if (src_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", src_grant); end
        n_tests++; if (src_next !== 2'b00) begin n_fail++; $display("FAIL reset_next: got %b expected 00", src_next); end
        n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", abort); end
        n_tests++; if (enc_payload !== 8'h00) begin n_fail++; $display("FAIL reset_payload: got %h expected 00", enc_payload); end
        n_tests++; if (enc_dest !== 48'h0 || enc_ethertype !== 16'h0) begin n_fail++; $display("FAIL reset_hdr: got %h/%h expected 0/0", enc_dest, enc_ethertype); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_tests++; if (m_enc_en !== 1'b0 || m_abort !== 1'b0) begin n_fail++; $display("FAIL reset_m: got en=%b abort=%b expected 0/0", m_enc_en, m_abort); end
        src_req = '0;
        enc_send_next = 1'b0;
    endtask

    task automatic test_single();
        int  idx;
        bit  sn, acc, last, done;
        do_reset();
        src_dest[47:0] = 48'hAABBCCDDEEFF;
        src_ethertype[15:0] = 16'h0806;
        src_dest[95:48] = 48'h112233445566;
        src_ethertype[31:16] = 16'h0800;
        src_req = 2'b01;
        src_ovalid = 2'b01;
        src_dout[7:0] = 8'h01;
        cyc();
        n_tests++; if (src_grant !== 2'b01 || enc_en !== 1'b1) begin n_fail++; $display("FAIL single_grant: got grant=%b en=%b expected 01/1", src_grant, enc_en); end
        n_tests++; if (enc_dest !== 48'hAABBCCDDEEFF) begin n_fail++; $display("FAIL single_dest: got %h expected aabbccddeeff", enc_dest); end
        n_tests++; if (enc_ethertype !== 16'h0806) begin n_fail++; $display("FAIL single_ety: got %h expected 0806", enc_ethertype); end
        src_req = 2'b00;
        idx = 1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            sn = (k % 3 != 2);
            enc_send_next = sn;
            src_ovalid[0] = (idx <= 28);
            src_dout[7:0] = 8'(idx);
            #1;
            n_tests++; if (src_next !== {1'b0, sn}) begin n_fail++; $display("FAIL single_next: got %b expected %b", src_next, {1'b0, sn}); end
            acc  = sn && (idx <= 28);
            last = (idx > 28);
            cyc();
            if (last) begin
                n_tests++; if (enc_en !== 1'b0 || src_grant !== 2'b00) begin n_fail++; $display("FAIL single_end: got en=%b grant=%b expected 0/00", enc_en, src_grant); end
                n_tests++; if (abort !== 1'b0 || enc_payload !== 8'h00) begin n_fail++; $display("FAIL single_end_abort: got abort=%b payload=%h expected 0/00", abort, enc_payload); end
                done = 1'b1;
            end else begin
                n_tests++; if (enc_en !== 1'b1 || abort !== 1'b0) begin n_fail++; $display("FAIL single_stream: got en=%b abort=%b expected 1/0", enc_en, abort); end
                if (acc) begin
                    n_tests++; if (enc_payload !== 8'(idx)) begin n_fail++; $display("FAIL single_payload: got %h expected %h", enc_payload, 8'(idx)); end
                    idx++;
                end
            end
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL single_timeout: got done=0 expected 1"); end
        enc_send_next = 1'b0;
        src_ovalid = '0;
    endtask

    task automatic test_simultaneous();
        int sent[2];
        int g_idx[4];
        int g_cyc[4];
        int g_fall[4];
        int g_cnt, cycle, fall_cyc;
        logic [1:0] acc, prev_grant;
        do_reset();
        sent[0] = 0; sent[1] = 0;
        g_cnt = 0; cycle = 0; fall_cyc = -1;
        src_req = 2'b11;
        enc_send_next = 1'b1;
        for (int k = 0; k < 400 && g_cnt < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                src_ovalid[i] = (sent[i] < 2);
                src_dout[8*i +: 8] = 8'(16 * i + sent[i]);
            end
            #1;
            acc = src_next & src_ovalid;
            prev_grant = src_grant;
            cyc();
            cycle++;
            n_tests++; if (src_grant !== 2'b00 && src_grant !== 2'b01 && src_grant !== 2'b10) begin n_fail++; $display("FAIL rr_onehot: got %b expected one-hot or 00", src_grant); end
            for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
            if (prev_grant != 2'b00 && src_grant == 2'b00) begin
                fall_cyc = cycle;
                sent[0] = 0; sent[1] = 0;
            end
            if (prev_grant == 2'b00 && src_grant != 2'b00) begin
                g_idx[g_cnt]  = src_grant[1] ? 1 : 0;
                g_cyc[g_cnt]  = cycle;
                g_fall[g_cnt] = fall_cyc;
                g_cnt++;
            end
        end
        n_tests++; if (g_cnt != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 4", g_cnt); end
        if (g_cnt > 0) begin
            n_tests++; if (g_cyc[0] != 1) begin n_fail++; $display("FAIL rr_first_latency: got cycle %0d expected 1", g_cyc[0]); end
        end
        for (int k = 0; k < g_cnt; k++) begin
            n_tests++; if (g_idx[k] != k % 2) begin n_fail++; $display("FAIL rr_order: grant %0d got src %0d expected %0d", k, g_idx[k], k % 2); end
            if (k > 0) begin
                n_tests++; if (g_cyc[k] - g_fall[k] != IFG + 1) begin n_fail++; $display("FAIL rr_gap: grant %0d got %0d expected %0d", k, g_cyc[k] - g_fall[k], IFG + 1); end
            end
        end
        enc_send_next = 1'b0;
        src_req = '0;
        src_ovalid = '0;
    endtask

    task automatic test_isolation();
        bit sn;
        do_reset();
        src_dest[47:0] = 48'hAABBCCDDEEFF;
        src_dest[95:48] = 48'h112233445566;
        src_req = 2'b11;
        src_ovalid = 2'b11;
        cyc();
        n_tests++; if (src_grant !== 2'b01) begin n_fail++; $display("FAIL iso_grant: got %b expected 01", src_grant); end
        src_req = 2'b10;
        for (int k = 0; k < 8; k++) begin
            sn = (k % 2 == 0);
            enc_send_next = sn;
            if (k == 3) src_dest[47:0] = 48'h0123456789AB;
            #1;
            n_tests++; if (src_next[1] !== 1'b0) begin n_fail++; $display("FAIL iso_next1: got %b expected 0", src_next[1]); end
            n_tests++; if (src_next[0] !== sn) begin n_fail++; $display("FAIL iso_next0: got %b expected %b", src_next[0], sn); end
            cyc();
            n_tests++; if (enc_dest !== 48'hAABBCCDDEEFF || src_grant !== 2'b01) begin n_fail++; $display("FAIL iso_hold: got dest=%h grant=%b expected aabbccddeeff/01", enc_dest, src_grant); end
        end
        src_ovalid[0] = 1'b0;
        enc_send_next = 1'b1;
        #1;
        n_tests++; if (src_next[1] !== 1'b0) begin n_fail++; $display("FAIL iso_next1_end: got %b expected 0", src_next[1]); end
        cyc();
        n_tests++; if (src_grant !== 2'b00 || enc_en !== 1'b0) begin n_fail++; $display("FAIL iso_end: got grant=%b en=%b expected 00/0", src_grant, enc_en); end
        enc_send_next = 1'b0;
        src_req = '0;
        src_ovalid = '0;
    endtask

    task automatic test_max();
        int  idx, pulses, aborts, c, fall, abort_cyc, regrant;
        bit  acc, prev_en;
        do_reset();
        src_dest[47:0] = 48'hAABBCCDDEEFF;
        src_ethertype[15:0] = 16'h0806;
        src_req = 2'b01;
        src_ovalid = 2'b01;
        enc_send_next = 1'b1;
        idx = 1; pulses = 0; aborts = 0; c = 0;
        fall = -1; abort_cyc = -1; regrant = -1;
        for (int k = 0; k < 60 && regrant < 0; k++) begin
            src_dout[7:0] = 8'(idx);
            src_ovalid[0] = (idx <= 10);
            #1;
            acc = m_src_next[0];
            if (acc) pulses++;
            prev_en = m_enc_en;
            cyc();
            c++;
            if (c == 1) begin
                n_tests++; if (m_src_grant !== 2'b01 || m_enc_dest !== 48'hAABBCCDDEEFF || m_enc_ethertype !== 16'h0806) begin n_fail++; $display("FAIL max_grant: got %b %h %h expected 01 aabbccddeeff 0806", m_src_grant, m_enc_dest, m_enc_ethertype); end
            end
            if (acc) begin
                n_tests++; if (m_enc_payload !== 8'(idx)) begin n_fail++; $display("FAIL max_payload: got %h expected %h", m_enc_payload, 8'(idx)); end
                idx++;
            end
            if (m_abort) begin
                aborts++;
                abort_cyc = c;
                n_tests++; if (m_enc_en !== 1'b0 || m_dbg_state !== 2'd3) begin n_fail++; $display("FAIL max_abort_en: got en=%b state=%0d expected 0/3", m_enc_en, m_dbg_state); end
            end
            if (prev_en && !m_enc_en) fall = c;
            if (!prev_en && m_enc_en && c > 1) regrant = c;
        end
        n_tests++; if (pulses != 4) begin n_fail++; $display("FAIL max_pulses: got %0d expected 4", pulses); end
        n_tests++; if (aborts != 1) begin n_fail++; $display("FAIL max_aborts: got %0d expected 1", aborts); end
        n_tests++; if (fall != 6 || abort_cyc != 6) begin n_fail++; $display("FAIL max_fall: got fall=%0d abort=%0d expected 6/6", fall, abort_cyc); end
        n_tests++; if (regrant - fall != IFG + 1) begin n_fail++; $display("FAIL max_regrant: got %0d expected %0d", regrant - fall, IFG + 1); end
        enc_send_next = 1'b0;
        src_req = '0;
        src_ovalid = '0;
    endtask

    task automatic test_reset_mid();
        int idx;
        bit acc;
        do_reset();
        src_req = 2'b01;
        src_ovalid = 2'b01;
        enc_send_next = 1'b1;
        cyc();
        idx = 1;
        for (int k = 0; k < 20 && idx <= 5; k++) begin
            src_dout[7:0] = 8'(idx);
            #1;
            acc = src_next[0];
            cyc();
            if (acc) idx++;
        end
        n_tests++; if (enc_en !== 1'b1 || enc_payload !== 8'h05) begin n_fail++; $display("FAIL rmid_pre: got en=%b payload=%h expected 1/05", enc_en, enc_payload); end
        rst = 1'b0;
        #1;
        n_tests++; if (enc_en !== 1'b0) begin n_fail++; $display("FAIL rmid_en: got %b expected 0", enc_en); end
        n_tests++; if (src_grant !== 2'b00) begin n_fail++; $display("FAIL rmid_grant: got %b expected 00", src_grant); end
        n_tests++; if (src_next !== 2'b00) begin n_fail++; $display("FAIL rmid_next: got %b expected 00", src_next); end
        #2;
        rst = 1'b1;
        cyc();
        n_tests++; if (src_grant !== 2'b01 || enc_en !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: got grant=%b en=%b expected 01/1", src_grant, enc_en); end
        enc_send_next = 1'b0;
        src_req = '0;
        src_ovalid = '0;
    endtask

    task automatic test_withdrawn();
        do_reset();
        src_req = 2'b01;
        src_ovalid = 2'b00;
        enc_send_next = 1'b1;
        cyc();
        n_tests++; if (src_grant !== 2'b01) begin n_fail++; $display("FAIL wd_grant: got %b expected 01", src_grant); end
        src_req = 2'b00;
        cyc();
        n_tests++; if (enc_en !== 1'b0 || dbg_state !== 2'd3) begin n_fail++; $display("FAIL wd_gap: got en=%b state=%0d expected 0/3", enc_en, dbg_state); end
        cyc();
        src_req = 2'b10;
        #1;
        n_tests++; if (src_next !== 2'b00) begin n_fail++; $display("FAIL wd_gap_next: got %b expected 00", src_next); end
        cyc();
        src_req = 2'b00;
        for (int k = 0; k < 25; k++) begin
            #1;
            n_tests++; if (src_grant !== 2'b00 || enc_en !== 1'b0 || src_next !== 2'b00) begin n_fail++; $display("FAIL wd_nogrant: got grant=%b en=%b next=%b expected 00/0/00", src_grant, enc_en, src_next); end
            cyc();
        end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL wd_idle: got %0d expected 0", dbg_state); end
        enc_send_next = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_simultaneous();
        test_isolation();
        test_max();
        test_reset_mid();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
